// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver:
// character codes, the active-low glyph table, scan state encoding
// and the all-off output constants.
package seg_pkg;

    // Character codes understood by the message sources
    localparam logic [5:0] CH_0 = 6'd0,  CH_1 = 6'd1,  CH_2 = 6'd2,  CH_3 = 6'd3;
    localparam logic [5:0] CH_4 = 6'd4,  CH_5 = 6'd5,  CH_6 = 6'd6,  CH_7 = 6'd7;
    localparam logic [5:0] CH_8 = 6'd8,  CH_9 = 6'd9;
    localparam logic [5:0] CH_A = 6'd10, CH_B = 6'd11, CH_C = 6'd12, CH_D = 6'd13;
    localparam logic [5:0] CH_E = 6'd14, CH_F = 6'd15, CH_G = 6'd16, CH_H = 6'd17;
    localparam logic [5:0] CH_I = 6'd18, CH_J = 6'd19, CH_K = 6'd20, CH_L = 6'd21;
    localparam logic [5:0] CH_M = 6'd22, CH_N = 6'd23, CH_O = 6'd24, CH_P = 6'd25;
    localparam logic [5:0] CH_Q = 6'd26, CH_R = 6'd27, CH_S = 6'd28, CH_T = 6'd29;
    localparam logic [5:0] CH_U = 6'd30, CH_V = 6'd31, CH_W = 6'd32, CH_X = 6'd33;
    localparam logic [5:0] CH_Y = 6'd34, CH_Z = 6'd35;
    localparam logic [5:0] CH_BLANK = 6'd36;

    // All-off values for the active-low pins
    localparam logic [7:0] SEG_OFF     = 8'hFF;
    localparam logic [3:0] AN_OFF      = 4'hF;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    // Active-low glyphs, bit order g,f,e,d,c,b,a. Letters that cannot be
    // drawn on seven segments (K, X) are blank. M is drawn as an inverted
    // U (a,b,c,e,f) and W as an open-top figure (b,c,d,e,f,g).
    localparam logic [6:0] GLYPH_TABLE [0:35] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10, // 0-9
        7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h42, 7'h09, 7'h79, 7'h61, // A-J
        7'h7F, 7'h47, 7'h48, 7'h2B, 7'h40, 7'h0C, 7'h18, 7'h2F, 7'h12, 7'h07, // K-T
        7'h41, 7'h63, 7'h01, 7'h7F, 7'h11, 7'h24                              // U-Z
    };

    // Scan sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHOW  = 2'd2
    } scan_state_e;

endpackage

// File: rtl/seg_char_decoder.sv
// Combinational character-code to active-low 7-segment glyph lookup.
// Codes outside the glyph table decode to all segments off.
module seg_char_decoder
    import seg_pkg::*;
(
    input  logic [5:0] code,
    output logic [6:0] pattern
);

    // Table lookup with a blank fallback for codes past the last letter
    always_comb begin
        if (code < CH_BLANK) begin
            pattern = GLYPH_TABLE[code];
        end else begin
            pattern = GLYPH_BLANK;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment scan driver. Owns the digit timebase,
// strobes the character source once per digit slot, captures the returned
// code after a fixed latency and drives active-low segments and anodes.
// Optional build macro SEG_DIM_EN adds a 'dim' input that limits the anode
// on-time to the first quarter of each digit slot while showing.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int CAP_LAT  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] char_in,
    input  logic [3:0] dp_mask,
    input  logic       disp_en,
`ifdef SEG_DIM_EN
    input  logic       dim,
`endif
    output logic [1:0] refresh,
    output logic       ref_sign,
    output logic [7:0] seg,
    output logic [3:0] an
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CAP_W = $clog2(CAP_LAT + 2);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CAP_W-1:0] CAP_LAST = CAP_W'(CAP_LAT);

    logic [DIV_W-1:0] div_cnt_r, div_cnt_s;
    logic [CAP_W-1:0] cap_cnt_r, cap_cnt_s;
    logic [1:0]       refresh_r, refresh_s;
    logic             ref_sign_r, ref_sign_s;
    logic [7:0]       seg_r, seg_s;
    logic [3:0]       an_r, an_s;
    logic             lit_r, lit_s;
    scan_state_e      state_r, state_s;
    logic             terminal_s;
    logic             dim_off_s;
    logic [6:0]       glyph_s;
    logic [3:0]       digit_an_s;

    seg_char_decoder u_decoder (
        .code    (char_in),
        .pattern (glyph_s)
    );

    assign terminal_s = (div_cnt_r == DIV_LAST);
    assign digit_an_s = ~(4'b0001 << refresh_r);

`ifdef SEG_DIM_EN
    localparam logic [DIV_W-1:0] DIM_LIMIT = DIV_W'(SCAN_DIV / 4);
    // Dimming blanks the anode once the slot counter leaves its first quarter
    assign dim_off_s = dim && (div_cnt_s >= DIM_LIMIT);
`else
    assign dim_off_s = 1'b0;
`endif

    // Next-state, timebase and output decisions for the scan sequencer
    always_comb begin
        div_cnt_s  = terminal_s ? {DIV_W{1'b0}} : div_cnt_r + DIV_W'(1);
        state_s    = state_r;
        refresh_s  = refresh_r;
        ref_sign_s = 1'b0;
        cap_cnt_s  = cap_cnt_r;
        seg_s      = seg_r;
        an_s       = an_r;
        lit_s      = lit_r;
        if (terminal_s) begin
            // New digit slot: advance the index, strobe the source, blank
            refresh_s  = refresh_r + 2'd1;
            ref_sign_s = 1'b1;
            cap_cnt_s  = {CAP_W{1'b0}};
            state_s    = FETCH;
            an_s       = AN_OFF;
            seg_s      = SEG_OFF;
            lit_s      = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    an_s  = AN_OFF;
                    seg_s = SEG_OFF;
                end
                FETCH: begin
                    cap_cnt_s = cap_cnt_r + CAP_W'(1);
                    if (cap_cnt_r == CAP_LAST) begin
                        // Source data is valid now; latch it for the slot
                        state_s = SHOW;
                        lit_s   = disp_en;
                        if (disp_en) begin
                            seg_s = {~dp_mask[refresh_r], glyph_s};
                            an_s  = dim_off_s ? AN_OFF : digit_an_s;
                        end else begin
                            seg_s = SEG_OFF;
                            an_s  = AN_OFF;
                        end
                    end else begin
                        an_s  = AN_OFF;
                        seg_s = SEG_OFF;
                    end
                end
                SHOW: begin
                    if (!disp_en) begin
                        // A disable mid-slot stays dark until the next capture
                        an_s  = AN_OFF;
                        seg_s = SEG_OFF;
                        lit_s = 1'b0;
                    end else begin
                        an_s  = (lit_r && !dim_off_s) ? digit_an_s : AN_OFF;
                        seg_s = seg_r;
                    end
                end
                default: begin
                    state_s = IDLE;
                    an_s    = AN_OFF;
                    seg_s   = SEG_OFF;
                    lit_s   = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset blanks the pins and parks on digit 3
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r  <= {DIV_W{1'b0}};
            cap_cnt_r  <= {CAP_W{1'b0}};
            refresh_r  <= 2'd3;
            ref_sign_r <= 1'b0;
            seg_r      <= SEG_OFF;
            an_r       <= AN_OFF;
            lit_r      <= 1'b0;
            state_r    <= IDLE;
        end else begin
            div_cnt_r  <= div_cnt_s;
            cap_cnt_r  <= cap_cnt_s;
            refresh_r  <= refresh_s;
            ref_sign_r <= ref_sign_s;
            seg_r      <= seg_s;
            an_r       <= an_s;
            lit_r      <= lit_s;
            state_r    <= state_s;
        end
    end

    assign refresh  = refresh_r;
    assign ref_sign = ref_sign_r;
    assign seg      = seg_r;
    assign an       = an_r;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver with SCAN_DIV=8, CAP_LAT=2.
// A table of per-slot records drives the source code, dp mask and enable
// and lists the hand-computed anode/segment values; a few directed
// sequences cover disable mid-slot and reset in SHOW and in FETCH.
module tb_seg_scan_driver;

    logic       clk;
    logic       rst_n;
    logic [5:0] char_in;
    logic [3:0] dp_mask;
    logic       disp_en;
    logic       dim;
    logic [1:0] refresh;
    logic       ref_sign;
    logic [7:0] seg;
    logic [3:0] an;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [5:0] code;
        logic [3:0] dp;
        logic       en;
        logic [1:0] ref_exp;
        logic [3:0] an_exp;
        logic [7:0] seg_exp;
    } vec_t;

    vec_t vecs [0:15];
    vec_t v;

    seg_scan_driver #(
        .SCAN_DIV (8),
        .CAP_LAT  (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .char_in  (char_in),
        .dp_mask  (dp_mask),
        .disp_en  (disp_en),
`ifdef SEG_DIM_EN
        .dim      (dim),
`endif
        .refresh  (refresh),
        .ref_sign (ref_sign),
        .seg      (seg),
        .an       (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for the fetch strobe, checking how many edges it took
    task automatic wait_ref(input int exp_wait, input string name);
        int   waited;
        logic found;
        waited = 0;
        found  = 1'b0;
        while (!found && waited < 40) begin
            tick();
            waited++;
            found = ref_sign;
        end
        check(name, 32'(waited), 32'(exp_wait));
    endtask

    // Entered one step after the strobe edge; runs through the capture edge
    task automatic slot_capture(input vec_t s);
        dp_mask = s.dp;
        disp_en = s.en;
        check("slot_refresh", 32'(refresh), 32'(s.ref_exp));
        check("slot_an_blank0", 32'(an), 32'hF);
        check("slot_seg_blank0", 32'(seg), 32'hFF);
        char_in = 6'd63;
        tick();
        check("ref_sign_one_cycle", 32'(ref_sign), 32'h0);
        check("slot_an_blank1", 32'(an), 32'hF);
        char_in = s.code;
        tick();
        check("slot_seg_blank2", 32'(seg), 32'hFF);
        tick();
        check("capture_an", 32'(an), 32'(s.an_exp));
        check("capture_seg", 32'(seg), 32'(s.seg_exp));
    endtask

    // Glitch char_in, optionally change disp_en, then check and wait for the next slot
    task automatic slot_finish(input logic en_mid, input logic [3:0] an_exp, input logic [7:0] seg_exp);
        char_in = 6'd1;
        disp_en = en_mid;
        tick();
        tick();
        check("show_an_hold", 32'(an), 32'(an_exp));
        check("show_seg_hold", 32'(seg), 32'(seg_exp));
        wait_ref(3, "slot_period");
    endtask

    initial begin
        // code, dp_mask, disp_en, refresh, expected an, expected seg
        vecs[0]  = '{6'd14, 4'b0000, 1'b1, 2'd0, 4'b1110, 8'h86};
        vecs[1]  = '{6'd21, 4'b0000, 1'b1, 2'd1, 4'b1101, 8'hC7};
        vecs[2]  = '{6'd14, 4'b0000, 1'b1, 2'd2, 4'b1011, 8'h86};
        vecs[3]  = '{6'd32, 4'b0000, 1'b1, 2'd3, 4'b0111, 8'h81};
        vecs[4]  = '{6'd12, 4'b0000, 1'b1, 2'd0, 4'b1110, 8'hC6};
        vecs[5]  = '{6'd21, 4'b0000, 1'b1, 2'd1, 4'b1101, 8'hC7};
        vecs[6]  = '{6'd14, 4'b0000, 1'b1, 2'd2, 4'b1011, 8'h86};
        vecs[7]  = '{6'd32, 4'b0000, 1'b1, 2'd3, 4'b0111, 8'h81};
        vecs[8]  = '{6'd40, 4'b0000, 1'b1, 2'd0, 4'b1110, 8'hFF};
        vecs[9]  = '{6'd0,  4'b0010, 1'b1, 2'd1, 4'b1101, 8'h40};
        vecs[10] = '{6'd1,  4'b1011, 1'b1, 2'd2, 4'b1011, 8'hF9};
        vecs[11] = '{6'd8,  4'b0000, 1'b1, 2'd3, 4'b0111, 8'h80};
        vecs[12] = '{6'd0,  4'b0001, 1'b1, 2'd0, 4'b1110, 8'h40};
        vecs[13] = '{6'd24, 4'b0000, 1'b1, 2'd1, 4'b1101, 8'hC0};
        vecs[14] = '{6'd22, 4'b0000, 1'b0, 2'd2, 4'b1111, 8'hFF};
        vecs[15] = '{6'd35, 4'b0000, 1'b1, 2'd3, 4'b0111, 8'hA4};

        rst_n   = 1'b1;
        char_in = 6'd0;
        dp_mask = 4'b0000;
        disp_en = 1'b1;
        dim     = 1'b0;
        #3;
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'hFF);
        check("rst_refresh", 32'(refresh), 32'h3);
        check("rst_ref_sign", 32'(ref_sign), 32'h0);
        rst_n = 1'b1;
        wait_ref(8, "first_ref_sign_delay");
        check("first_fetch_refresh", 32'(refresh), 32'h0);

        // Table-driven slots: capture, decode, dp, blank codes, disable at capture
        for (int i = 0; i < 16; i++) begin
            slot_capture(vecs[i]);
            slot_finish(1'b1, vecs[i].an_exp, vecs[i].seg_exp);
        end

        // Disable mid-SHOW, keep scanning dark, re-enable mid-slot, resume at capture
        v = '{6'd8, 4'b0000, 1'b1, 2'd0, 4'b1110, 8'h80};
        slot_capture(v);
        slot_finish(1'b0, 4'hF, 8'hFF);
        v = '{6'd8, 4'b0000, 1'b0, 2'd1, 4'hF, 8'hFF};
        slot_capture(v);
        slot_finish(1'b1, 4'hF, 8'hFF);
        v = '{6'd8, 4'b0000, 1'b1, 2'd2, 4'b1011, 8'h80};
        slot_capture(v);
        slot_finish(1'b1, 4'b1011, 8'h80);

        // Reset while a digit is lit blanks the pins without waiting for a clock
        v = '{6'd24, 4'b0000, 1'b1, 2'd3, 4'b0111, 8'hC0};
        slot_capture(v);
        tick();
        rst_n = 1'b0;
        #1;
        check("async_rst_an", 32'(an), 32'hF);
        check("async_rst_seg", 32'(seg), 32'hFF);
        check("async_rst_refresh", 32'(refresh), 32'h3);
        tick();
        tick();
        rst_n = 1'b1;
        wait_ref(8, "show_rst_restart_delay");
        check("show_rst_restart_refresh", 32'(refresh), 32'h0);

        // Reset one edge into FETCH (cap_cnt=1)
        tick();
        rst_n = 1'b0;
        #1;
        check("fetch_rst_refresh", 32'(refresh), 32'h3);
        check("fetch_rst_an", 32'(an), 32'hF);
        check("fetch_rst_seg", 32'(seg), 32'hFF);
        check("fetch_rst_ref_sign", 32'(ref_sign), 32'h0);
        tick();
        rst_n = 1'b1;
        wait_ref(8, "fetch_rst_restart_delay");
        v = '{6'd12, 4'b0000, 1'b1, 2'd0, 4'b1110, 8'hC6};
        slot_capture(v);
        slot_finish(1'b1, 4'b1110, 8'hC6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
